// File: rtl/seq_monitor_if.sv
// Bundle for seq_monitor: sample inputs from the upstream FSM and monitor results.
interface seq_monitor_if;
    logic       en;
    logic       clr;
    logic       a;
    logic [2:0] code;
    logic       illegal;
    logic       trans_err;
    logic       err;
    logic [3:0] err_cnt;
    logic       match;
    logic [3:0] match_cnt;
    logic [2:0] last_code;

    modport master (
        output en, clr, a, code,
        input  illegal, trans_err, err, err_cnt, match, match_cnt, last_code
    );

    modport slave (
        input  en, clr, a, code,
        output illegal, trans_err, err, err_cnt, match, match_cnt, last_code
    );
endinterface

// File: rtl/seq_monitor.sv
// Watches an upstream state machine's code stream: flags illegal codes and bad
// transitions, counts errors, and detects the 2,4,1,6,7 sequence.
module seq_monitor (
    input  logic          clk,
    input  logic          reset,
    seq_monitor_if.slave  mon
);

    typedef enum logic [2:0] {M0, M1, M2, M3, M4} mstate_e;

    mstate_e    mstate_q,    mstate_d;
    logic       have_prev_q, have_prev_d;
    logic       prev_a_q,    prev_a_d;
    logic [2:0] last_code_q, last_code_d;
    logic       illegal_q,   illegal_d;
    logic       trans_err_q, trans_err_d;
    logic       err_q,       err_d;
    logic [3:0] err_cnt_q,   err_cnt_d;
    logic       match_q,     match_d;
    logic [3:0] match_cnt_q, match_cnt_d;

    logic       code_illegal;
    logic       code_bad_trans;

    function automatic logic [2:0] successor(input logic [2:0] c, input logic a_in);
        logic [2:0] nxt;
        case (c)
            3'd2:    nxt = 3'd4;
            3'd1:    nxt = 3'd6;
            3'd6:    nxt = 3'd7;
            3'd4:    nxt = a_in ? 3'd1 : 3'd6;
            3'd7:    nxt = a_in ? 3'd4 : 3'd2;
            default: nxt = 3'd0;
        endcase
        return nxt;
    endfunction

    assign code_illegal   = !(mon.code inside {3'd1, 3'd2, 3'd4, 3'd6, 3'd7});
    // An illegal code can never equal a successor, so both flags may fire together.
    assign code_bad_trans = have_prev_q && (mon.code != successor(last_code_q, prev_a_q));

    always_comb begin
        mstate_d    = mstate_q;
        have_prev_d = have_prev_q;
        prev_a_d    = prev_a_q;
        last_code_d = last_code_q;
        illegal_d   = 1'b0;
        trans_err_d = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        match_d     = 1'b0;
        match_cnt_d = match_cnt_q;

        if (mon.clr) begin
            mstate_d    = M0;
            have_prev_d = 1'b0;
            prev_a_d    = 1'b0;
            last_code_d = '0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
            match_cnt_d = '0;
        end else if (mon.en) begin
            last_code_d = mon.code;
            prev_a_d    = mon.a;
            have_prev_d = !code_illegal;
            illegal_d   = code_illegal;
            trans_err_d = code_bad_trans;

            if (code_illegal || code_bad_trans) begin
                err_d = 1'b1;
                if (err_cnt_q != 4'd15) begin
                    err_cnt_d = err_cnt_q + 4'd1;
                end
            end

            // Mismatch fallback: a 2 restarts the pattern, anything else resets it.
            mstate_d = (mon.code == 3'd2) ? M1 : M0;
            case (mstate_q)
                M0: if (mon.code == 3'd2) mstate_d = M1;
                M1: if (mon.code == 3'd4) mstate_d = M2;
                M2: if (mon.code == 3'd1) mstate_d = M3;
                M3: if (mon.code == 3'd6) mstate_d = M4;
                M4: begin
                    if (mon.code == 3'd7) begin
                        mstate_d = M0;
                        match_d  = 1'b1;
                        if (match_cnt_q != 4'd15) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                        end
                    end
                end
                default: mstate_d = M0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstate_q    <= M0;
            have_prev_q <= 1'b0;
            prev_a_q    <= 1'b0;
            last_code_q <= '0;
            illegal_q   <= 1'b0;
            trans_err_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            match_q     <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            mstate_q    <= mstate_d;
            have_prev_q <= have_prev_d;
            prev_a_q    <= prev_a_d;
            last_code_q <= last_code_d;
            illegal_q   <= illegal_d;
            trans_err_q <= trans_err_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            match_q     <= match_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign mon.illegal   = illegal_q;
    assign mon.trans_err = trans_err_q;
    assign mon.err       = err_q;
    assign mon.err_cnt   = err_cnt_q;
    assign mon.match     = match_q;
    assign mon.match_cnt = match_cnt_q;
    assign mon.last_code = last_code_q;

endmodule

// File: doc/seq_monitor.md
SEQ_MONITOR -- requirements
Module: seq_monitor

Interface
REQ-001 The module SHALL have port `clk`, input, 1 bit: single clock, rising-edge active.
REQ-002 The module SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port `en`, input, 1 bit: sample enable; `code` and `a` are sampled only when high.
REQ-004 The module SHALL have port `clr`, input, 1 bit: synchronous clear of all monitor state.
REQ-005 The module SHALL have port `a`, input, 1 bit: the input bit fed to the upstream state machine in the same cycle.
REQ-006 The module SHALL have port `code`, input, 3 bits: the state code produced by the upstream state machine.
REQ-007 The module SHALL have port `illegal`, output, 1 bit: one-cycle pulse; the sampled code was not in {1,2,4,6,7}.
REQ-008 The module SHALL have port `trans_err`, output, 1 bit: one-cycle pulse; the sampled code differs from the expected successor.
REQ-009 The module SHALL have port `err`, output, 1 bit: sticky error flag.
REQ-010 The module SHALL have port `err_cnt`, output, 4 bits: saturating count of erroneous samples.
REQ-011 The module SHALL have port `match`, output, 1 bit: one-cycle pulse; the sequence 2,4,1,6,7 has completed.
REQ-012 The module SHALL have port `match_cnt`, output, 4 bits: saturating count of matches.
REQ-013 The module SHALL have port `last_code`, output, 3 bits: the most recently sampled code.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 A "sample" SHALL occur on each rising `clk` edge with `en`=1 and `clr`=0. All pulse outputs SHALL reflect that sample in the following cycle.
REQ-016 A cycle with `en`=0 SHALL hold all state and counters and SHALL force `illegal`, `trans_err` and `match` to 0.
REQ-017 `clr`=1 SHALL take priority over `en`. It SHALL zero all outputs, counters, `err`, the matcher, and `have_prev`.
REQ-018 The expected successor SHALL be computed from the previous sample's code and `a`:
- 2→4
- 1→6
- 6→7
- 4: `a`=0→6, `a`=1→1
- 7: `a`=0→2, `a`=1→4
REQ-019 Codes 0, 3 and 5 SHALL be illegal. An illegal sample SHALL pulse `illegal` and SHALL clear `have_prev`.
REQ-020 The transition check SHALL run only when `have_prev`=1. A mismatch SHALL pulse `trans_err`.
REQ-021 `have_prev` SHALL be set by any legal sample.
REQ-022 The first sample after reset/`clr`, and the sample immediately following an illegal sample, SHALL NOT produce `trans_err`.
REQ-023 Any sample with `illegal` or `trans_err` SHALL set `err`. `err` SHALL stay set until reset or `clr`.
REQ-024 Any sample with `illegal` or `trans_err` SHALL increment `err_cnt` by exactly 1, including when both conditions occur in the same sample.
REQ-025 `err_cnt` SHALL saturate at 15.
REQ-026 The matcher SHALL be an FSM with states M0–M4, where Mk means the first k codes of 2,4,1,6,7 have been matched:
- if state Mk and the sample equals pattern[k]: k<4 → Mk+1; k=4 → pulse `match` and go to M0
- on a mismatch: sample=2 → M1, else → M0
REQ-027 Overlapping matches SHALL be handled by the rule in REQ-026. Illegal codes SHALL be treated as mismatches (→M0).
REQ-028 `match_cnt` SHALL increment on each match and SHALL saturate at 15.
REQ-029 The matcher SHALL operate independently of the transition and error checks.
REQ-030 Matcher state SHALL be internal and not visible as an output.
REQ-031 `last_code` SHALL update on every sample, whether the sampled code is legal or illegal.

Reset
REQ-032 `reset`=0 SHALL asynchronously and immediately clear all outputs, `err_cnt`, `match_cnt`, the matcher (to M0) and `have_prev`.
REQ-033 This clearing SHALL occur regardless of `clk`, `en` or `clr`.
REQ-034 Assertion of `reset` in mid-sequence SHALL discard any partial match.
REQ-035 After release of `reset`, the first sample SHALL be treated as having no predecessor.

Verification
REQ-036 Legal walk: reset; en=1; drive (code,a) = (2,0),(4,1),(1,0),(6,0),(7,0),(2,0). Required: match=1 exactly one cycle after the 7 sample; match_cnt=1; err=0; err_cnt=0.
REQ-037 Bad successor: drive (2,0) then (6,0). Required: trans_err=1 one cycle after the 6 sample; err=1; err_cnt=1; illegal=0.
REQ-038 Illegal code: drive (4,0),(3,0),(1,0). Required: illegal=1 after the 3 sample; no trans_err on the 1 sample; err_cnt=1.
REQ-039 Saturation: drive 20 consecutive code=5 samples. Required: err_cnt holds at 15; err=1.
REQ-040 Overlapping prefix: drive 2,2,4,1,6,7. Required: one match pulse; match_cnt=1.
REQ-041 Enable and clear: drive 2,4, then en=0 for 3 cycles, then 1,6,7 with en=1. Required: match=1 after 7.
REQ-042 Then assert clr=1 together with en=1 for 1 cycle. Required: all counters and flags=0 on the next cycle.
REQ-043 Asynchronous reset: pulse reset low between clock edges after 2,4,1. Required: outputs clear immediately; a subsequent 6,7 produces no match.
